// File: rtl/seq_addsub_chunked.sv
// Multi-cycle adder/subtractor that adds one CHUNK-bit slice per clock.
// The carry between slices is held in a register, so the carry chain is only CHUNK+1 bits long.
module seq_addsub_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx_reg;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_next;

  // Slice adder plus the partial result with the current slice merged in,
  // so the final slice can be written straight into out.
  always_comb begin
    sum = {1'b0, a_reg[int'(idx_reg) * CHUNK +: CHUNK]}
        + {1'b0, b_reg[int'(idx_reg) * CHUNK +: CHUNK]}
        + (CHUNK + 1)'(carry_reg);
    res_next = res_reg;
    res_next[int'(idx_reg) * CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, with the +1 entering as the initial carry.
            a_reg     <= i1;
            b_reg     <= sub ? ~i2 : i2;
            carry_reg <= sub;
            idx_reg   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          res_reg   <= res_next;
          carry_reg <= sum[CHUNK];
          idx_reg   <= idx_reg + 1'b1;
          if (idx_reg == LAST) begin
            out       <= res_next;
            cout      <= sum[CHUNK];
            ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (res_next[WIDTH-1] != a_reg[WIDTH-1]);
            zero      <= ~|res_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Scoreboard bench for seq_addsub_chunked: three instances (CHUNK=8, 32, 1) share stimulus,
// expected results are queued at issue time and a negedge monitor pops them on done.
module tb_seq_addsub_chunked;

  localparam int NDUT = 3;
  localparam int CH [NDUT] = '{8, 32, 1};

  typedef struct {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] i1;
  logic [31:0] i2;

  logic        in_ready_w [NDUT];
  logic        busy_w     [NDUT];
  logic        done_w     [NDUT];
  logic [31:0] out_w      [NDUT];
  logic        cout_w     [NDUT];
  logic        ovf_w      [NDUT];
  logic        zero_w     [NDUT];

  exp_t sb [NDUT][$];
  int   tests = 0;
  int   fails = 0;
  int   cnt       [NDUT];
  bit   pend      [NDUT];
  bit   prev_done [NDUT];

  always #5 clk = ~clk;

  seq_addsub_chunked #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .i1(i1), .i2(i2),
    .in_ready(in_ready_w[0]), .busy(busy_w[0]), .done(done_w[0]), .out(out_w[0]),
    .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]));

  seq_addsub_chunked #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .i1(i1), .i2(i2),
    .in_ready(in_ready_w[1]), .busy(busy_w[1]), .done(done_w[1]), .out(out_w[1]),
    .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]));

  seq_addsub_chunked #(.WIDTH(32), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .i1(i1), .i2(i2),
    .in_ready(in_ready_w[2]), .busy(busy_w[2]), .done(done_w[2]), .out(out_w[2]),
    .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (CHUNK=%0d): got 0x%08h, expected 0x%08h", nm, CH[d], act, exp);
    end
  endtask

  // Monitor: latency, busy, one-cycle done, and result/flag comparison.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n) begin
        pend[d]      = 1'b0;
        prev_done[d] = 1'b0;
      end else begin
        if (prev_done[d]) chk("ready_after_done", d, 32'(in_ready_w[d] && !done_w[d]), 32'd1);
        if (pend[d]) cnt[d]++;
        if (pend[d] && cnt[d] == 1) chk("busy_in_calc", d, 32'(busy_w[d]), 32'd1);
        if (done_w[d]) begin
          if (sb[d].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done (CHUNK=%0d): got done=1, expected no done", CH[d]);
          end else begin
            exp_t e;
            e = sb[d].pop_front();
            $display("[TB] CHUNK=%0d %s: out=0x%08h cout=%0b ovf=%0b zero=%0b edges=%0d",
                     CH[d], e.name, out_w[d], cout_w[d], ovf_w[d], zero_w[d], cnt[d] - 1);
            chk({e.name, "_out"},  d, out_w[d], e.out);
            chk({e.name, "_cout"}, d, 32'(cout_w[d]), 32'(e.cout));
            chk({e.name, "_ovf"},  d, 32'(ovf_w[d]),  32'(e.ovf));
            chk({e.name, "_zero"}, d, 32'(zero_w[d]), 32'(e.zero));
            chk({e.name, "_latency"}, d, 32'(pend[d] ? cnt[d] - 1 : -1), 32'(32 / CH[d]));
          end
          pend[d] = 1'b0;
        end
        prev_done[d] = done_w[d];
        if (in_ready_w[d] && start) begin
          pend[d] = 1'b1;
          cnt[d]  = 0;
        end
      end
    end
  end

  task automatic push_all(input logic [31:0] eo, input logic ec, input logic eov,
                          input logic ez, input string nm);
    exp_t e;
    e.out = eo; e.cout = ec; e.ovf = eov; e.zero = ez; e.name = nm;
    for (int d = 0; d < NDUT; d++) sb[d].push_back(e);
  endtask

  task automatic flush_all();
    for (int d = 0; d < NDUT; d++) sb[d].delete();
  endtask

  // Called at posedge+1; returns at posedge+1 once every instance has reported.
  task automatic wait_all(input string nm);
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 200 && !empty; c++) begin
      @(posedge clk); #1;
      empty = (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
    end
    if (!empty) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done within 200 cycles, expected done", nm);
      flush_all();
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic ec, input logic eov,
                       input logic ez, input string nm);
    push_all(eo, ec, eov, ez, nm);
    start = 1'b1; sub = s; i1 = a; i2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_all(nm);
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int d = 0; d < NDUT; d++) begin
      chk({nm, "_out"},      d, out_w[d], 32'h0);
      chk({nm, "_flags"},    d, {29'b0, cout_w[d], ovf_w[d], zero_w[d]}, 32'h0);
      chk({nm, "_done"},     d, 32'(done_w[d]), 32'd0);
      chk({nm, "_busy"},     d, 32'(busy_w[d]), 32'd0);
      chk({nm, "_in_ready"}, d, 32'(in_ready_w[d]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; i1 = '0; i2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, "add_5_3");
    issue(1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, "add_ffffffff_1");
    issue(1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, "add_7fffffff_1");
    issue(1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "sub_80000000_1");
    issue(1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "sub_5_7");
    issue(1'b1, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0, "sub_7_5");
    issue(1'b1, 32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b1, 1'b0, 1'b1, "sub_equal");
    issue(1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h21436587, 1'b0, 1'b0, 1'b0, "add_mixed");

    // Start held high with new operands while busy must be ignored.
    push_all(32'h00000030, 1'b0, 1'b0, 1'b0, "ignore_start");
    start = 1'b1; sub = 1'b0; i1 = 32'h00000010; i2 = 32'h00000020;
    @(posedge clk); #1;
    sub = 1'b1; i1 = 32'hDEAD0000; i2 = 32'h00001111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_all("ignore_start");

    // Reset mid-operation: outputs clear at once and the aborted op never reports.
    start = 1'b1; sub = 1'b0; i1 = 32'h00000050; i2 = 32'h00000005;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush_all();
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_addsub_chunked.md
Name: seq_addsub_chunked

Overview:
- Parametrised, multi-cycle adder/subtractor. It is the successor to the fixed 32-bit ripple adder.
- It processes one CHUNK-bit slice per clock and carries between slices in a register. This trades latency for a short carry chain.
- It adds a subtract mode, start/done handshake, and carry, signed-overflow and zero flags.
- It sits beside the ALU datapath and serves PC/offset and multi-cycle arithmetic where timing is tight.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle. 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when in_ready=1
- sub  input  1  0: i1+i2, 1: i1-i2. Sampled with start.
- i1  input  WIDTH  operand A. Sampled with start.
- i2  input  WIDTH  operand B. Sampled with start.
- in_ready  output  1  high only in IDLE
- busy  output  1  high in CALC
- done  output  1  one-cycle pulse when the result becomes valid
- out  output  WIDTH  result. Held until the next done.
- cout  output  1  carry out of the MSB. For subtract this means no-borrow (1 when i1 ≥ i2 unsigned).
- ovf  output  1  two's-complement signed overflow
- zero  output  1  out == 0

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, all internal registers 0.
  - out=0, cout=0, ovf=0, zero=0, done=0, busy=0, in_ready=1.
  - An operation in flight is discarded; no done is produced for it.
- IDLE:
  - in_ready=1.
  - On a rising edge with start=1:
    - latch A=i1, B'=(sub ? ~i2 : i2), carry=sub, idx=0.
    - go to CALC.
  - start=0: stay in IDLE.
- CALC:
  - busy=1, in_ready=0.
  - Each edge:
    - {c, s} = A[idx*CHUNK +: CHUNK] + B'[idx*CHUNK +: CHUNK] + carry, evaluated at CHUNK+1 bits.
    - store s into the result slice idx; carry ← c; idx ← idx+1.
  - When idx == NCHUNK-1 is processed, go to DONE. out/cout/ovf/zero are loaded on that same edge.
- DONE:
  - done=1 for exactly one cycle, in_ready=0.
  - Next edge: go to IDLE unconditionally.
- Latency: if start is accepted at edge k, done is high in the cycle following edge k+NCHUNK.
  - NCHUNK=4: done is high after the 4th edge following acceptance.
  - Throughput: one operation per NCHUNK+2 cycles.
- start while busy or done is ignored, not queued. Operand, sub or start changes outside IDLE have no effect.
- Flags, computed from latched values:
  - cout = final carry.
  - ovf = (A[MSB] == B'[MSB]) && (out[MSB] != A[MSB]).
  - zero = ~|out.
- Result width is WIDTH; the carry is not appended. Wrap-around is modulo 2^WIDTH.
- Outputs out/cout/ovf/zero change only on the DONE-entry edge or on reset. They are stable at all other times.
- CHUNK=WIDTH is legal: NCHUNK=1, a single CALC cycle.
- idx is sized $clog2(NCHUNK) with a minimum of 1 bit.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
1. Add 0x00000005 + 0x00000003, sub=0 -> out=0x00000008, cout=0, ovf=0, zero=0. done is high exactly 4 edges after acceptance and lasts 1 cycle. in_ready returns high the next cycle.
2. Add 0xFFFFFFFF + 0x00000001 -> out=0x00000000, cout=1, zero=1, ovf=0. The carry propagates across all 4 chunks.
3. Add 0x7FFFFFFF + 0x00000001 -> out=0x80000000, ovf=1, cout=0. Then subtract 0x80000000 - 0x00000001 -> out=0x7FFFFFFF, ovf=1, cout=1.
4. Subtract 5-7 -> out=0xFFFFFFFE, cout=0, ovf=0. Subtract 7-5 -> out=0x00000002, cout=1. Subtract 0x1234ABCD-0x1234ABCD -> out=0, zero=1, cout=1.
5. Issue start with new operands during CALC: ignored, and the first result is unchanged. Then pulse rst_n low during CALC: all outputs 0 immediately, no done pulse, and the next request computes correctly.
6. Re-run tests 1–4 with CHUNK=32 (done 1 edge after acceptance) and CHUNK=1 (done 32 edges after acceptance) -> identical out/flag values.
